// File: rtl/ripple_carry_adder_4bit.sv
// Registered ripple-carry adder: WIDTH chained full-adder cells with optional operand register.
// Outputs sum, carry-out, two's-complement overflow and zero flag on registered ports.
module ripple_carry_adder_4bit #(
   parameter int unsigned WIDTH  = 4,
   parameter bit          IN_REG = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             out_valid
);

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic             w_cin;
   logic             w_valid;

   if (IN_REG) begin : g_in_reg
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic             r_cin;
      logic             r_valid;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_valid <= 1'b0;
         end else begin
            r_valid <= in_valid;
            if (in_valid) begin
               r_a   <= a;
               r_b   <= b;
               r_cin <= cin;
            end
         end
      end

      assign w_a     = r_a;
      assign w_b     = r_b;
      assign w_cin   = r_cin;
      assign w_valid = r_valid;
   end else begin : g_no_in_reg
      assign w_a     = a;
      assign w_b     = b;
      assign w_cin   = cin;
      assign w_valid = in_valid;
   end

   // w_c[i] is the carry into cell i; w_c[WIDTH] is the carry out of the MSB cell.
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_s;

   always_comb begin
      w_c    = '0;
      w_s    = '0;
      w_c[0] = w_cin;
      for (int i = 0; i < int'(WIDTH); i++) begin
         w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
         w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
      end
   end

   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_overflow;
   logic             r_zero;
   logic             r_out_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= w_valid;
         if (w_valid) begin
            r_sum      <= w_s;
            r_cout     <= w_c[WIDTH];
            r_overflow <= w_c[WIDTH] ^ w_c[WIDTH-1];
            r_zero     <= (w_s == '0);
         end
      end
   end

   assign sum       = r_sum;
   assign cout      = r_cout;
   assign overflow  = r_overflow;
   assign zero      = r_zero;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// Scoreboard bench: both IN_REG builds share stimulus; an arithmetic model queues expected results.
module tb_ripple_carry_adder_4bit;

   typedef struct {
      logic [3:0] sum;
      logic       cout;
      logic       ovf;
      logic       zero;
      int         due;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;

   logic [3:0] sum_w  [2];
   logic       cout_w [2];
   logic       ovf_w  [2];
   logic       zero_w [2];
   logic       ov_w   [2];

   exp_t q    [2][$];
   exp_t last [2];
   int   cyc     = 0;
   int   rst_cyc = -1;
   int   n_chk   = 0;
   int   n_fail  = 0;
   bit   started = 1'b0;
   bit   done    = 1'b0;

   ripple_carry_adder_4bit #(.WIDTH(4), .IN_REG(1'b0)) u_dut0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sum      (sum_w[0]),
      .cout     (cout_w[0]),
      .overflow (ovf_w[0]),
      .zero     (zero_w[0]),
      .out_valid(ov_w[0])
   );

   ripple_carry_adder_4bit #(.WIDTH(4), .IN_REG(1'b1)) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sum      (sum_w[1]),
      .cout     (cout_w[1]),
      .overflow (ovf_w[1]),
      .zero     (zero_w[1]),
      .out_valid(ov_w[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: plain integer arithmetic, unsigned for sum/cout, signed range test for overflow.
   function automatic exp_t model(logic [3:0] x, logic [3:0] y, logic c, int due);
      exp_t e;
      int   total;
      int   sx;
      int   sy;
      int   st;
      total  = int'(x) + int'(y) + int'(c);
      sx     = (int'(x) > 7) ? int'(x) - 16 : int'(x);
      sy     = (int'(y) > 7) ? int'(y) - 16 : int'(y);
      st     = sx + sy + int'(c);
      e.sum  = 4'(total % 16);
      e.cout = (total >= 16);
      e.ovf  = (st > 7) || (st < -8);
      e.zero = ((total % 16) == 0);
      e.due  = due;
      return e;
   endfunction

   function automatic exp_t rst_exp();
      exp_t e;
      e.sum  = 4'd0;
      e.cout = 1'b0;
      e.ovf  = 1'b0;
      e.zero = 1'b1;
      e.due  = 0;
      return e;
   endfunction

   task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, idx, cyc, act, exp);
      end
   endtask

   task automatic step(bit r, bit v, logic [3:0] x, logic [3:0] y, logic c);
      rst_n    = r;
      in_valid = v;
      a        = x;
      b        = y;
      cin      = c;
      @(posedge clk);
      #1;
      cyc++;
      if (!r) begin
         q[0].delete();
         q[1].delete();
         rst_cyc = cyc;
         started = 1'b1;
      end else if (v) begin
         q[0].push_back(model(x, y, c, cyc));
         q[1].push_back(model(x, y, c, cyc + 1));
      end
   endtask

   // Monitor: pops when a result is due, otherwise expects held outputs.
   initial begin
      forever begin
         @(negedge clk);
         if (started && !done) begin
            for (int i = 0; i < 2; i++) begin
               bit exp_v;
               exp_v = 1'b0;
               if (rst_cyc == cyc) last[i] = rst_exp();
               if (q[i].size() > 0 && q[i][0].due == cyc) begin
                  exp_v   = 1'b1;
                  last[i] = q[i].pop_front();
               end
               chk("out_valid", i, 8'(ov_w[i]), 8'(exp_v));
               chk("sum", i, 8'(sum_w[i]), 8'(last[i].sum));
               chk("cout", i, 8'(cout_w[i]), 8'(last[i].cout));
               chk("overflow", i, 8'(ovf_w[i]), 8'(last[i].ovf));
               chk("zero", i, 8'(zero_w[i]), 8'(last[i].zero));
            end
         end
      end
   end

   initial begin
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      // Directed corner cases
      step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
      step(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0);
      step(1'b1, 1'b1, 4'b0011, 4'b0101, 1'b0);
      step(1'b1, 1'b1, 4'b1111, 4'b0001, 1'b0);
      step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      // Reset while an IN_REG=1 operand is in flight
      step(1'b1, 1'b1, 4'd7, 4'd7, 1'b0);
      step(1'b0, 1'b1, 4'd9, 4'd9, 1'b1);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      // Exhaustive back-to-back sweep
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int c = 0; c < 2; c++)
               step(1'b1, 1'b1, 4'(x), 4'(y), 1'(c));
      // Random traffic with gaps and occasional reset
      for (int k = 0; k < 300; k++)
         step(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0),
              4'($urandom), 4'($urandom), 1'($urandom));
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      @(negedge clk);
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
